mem_arbiter: RTL

Parametrised N-channel arbiter that merges several core-side memory masters (instruction fetch, data read, data write, debug/DMA) onto one shared memory port. It supports up to RESP_DEPTH outstanding reads, returns read data in order to the issuing channel through a channel-ID FIFO, and keeps a request locked until the memory accepts it. It sits between `riscv` and the memory model or bus bridge and replaces the fixed three-state port merger.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_arbiter_resp_fifo.sv | 66 ++++++
 rtl/mem_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory-port arbiter.
package mem_arb_pkg;

    // Arbiter FSM: free arbitration or grant locked to one channel.
    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Width of a channel index; never less than one bit.
    function automatic int calc_ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_resp_fifo.sv
// In-order FIFO of channel IDs for outstanding reads.
// A push while full is accepted only when a pop happens in the same cycle.
import mem_arb_pkg::*;

module resp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     store_q [DEPTH];
    logic [W-1:0]     store_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == {CNT_W{1'b0}});
    assign dout  = store_q[rd_ptr_q];

    // Qualify push/pop and compute next pointers, storage and occupancy.
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        store_d   = store_q;
        store_d[wr_ptr_q] = do_push_s ? din : store_q[wr_ptr_q];
        wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers, cleared to empty on reset.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            store_q  <= store_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel arbiter merging core-side masters onto one memory port.
// Reads are tracked in an ID FIFO so in-order responses are routed back.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (lowest index wins) with no pointer register.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int NCH        = 3,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RESP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetb,
    input  logic                       stall,
    input  logic [NCH-1:0]             ch_valid,
    output logic [NCH-1:0]             ch_ready,
    input  logic [NCH-1:0]             ch_we,
    input  logic [NCH*ADDR_W-1:0]      ch_addr,
    input  logic [NCH*DATA_W-1:0]      ch_wdata,
    input  logic [NCH*DATA_W/8-1:0]    ch_wstrb,
    output logic [NCH-1:0]             ch_rvalid,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic [DATA_W/8-1:0]        mem_wstrb,
    input  logic                       mem_rvalid,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       resp_err
);

    localparam int CH_W   = calc_ch_w(NCH);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
    logic              resp_err_q, resp_err_d;

    logic [NCH-1:0]    eligible_s;
    logic              sel_vld_s;
    logic [CH_W-1:0]   sel_s;
    logic              grant_vld_s;
    logic [CH_W-1:0]   grant_s;
    logic              accept_s;

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CH_W-1:0]   fifo_dout_s;

    assign fifo_pop_s  = resetb && mem_rvalid && !fifo_empty_s;
    assign accept_s    = resetb && grant_vld_s && mem_ready;
    assign fifo_push_s = accept_s && !ch_we[grant_s];
    assign resp_err    = resp_err_q;

    // A read may only win if its ID fits in the FIFO this cycle; stall blocks all.
    always_comb begin
        eligible_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            eligible_s[i] = !stall && ch_valid[i] &&
                            (ch_we[i] || !fifo_full_s || fifo_pop_s);
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;

    // Channel index base+k, wrapped into 0..NCH-1.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        s = (s >= NCH) ? (s - NCH) : s;
        return CH_W'(s);
    endfunction

    // Round-robin search starting at the channel after the last accepted one.
    always_comb begin
        sel_vld_s = 1'b0;
        sel_s     = {CH_W{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            sel_s     = (!sel_vld_s && eligible_s[wrap_add(rr_ptr_q, k)]) ?
                        wrap_add(rr_ptr_q, k) : sel_s;
            sel_vld_s = sel_vld_s | eligible_s[wrap_add(rr_ptr_q, k)];
        end
        rr_ptr_d = accept_s ? wrap_add(grant_s, 1) : rr_ptr_q;
    end

    // Search start pointer, moved only by an accepted request.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rr_ptr_q <= {CH_W{1'b0}};
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: scanning downward leaves the lowest eligible index.
    always_comb begin
        sel_vld_s = |eligible_s;
        sel_s     = {CH_W{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            sel_s = eligible_s[i] ? CH_W'(i) : sel_s;
        end
    end
`endif

    // FSM next state: arbitrate freely, or hold the grant until accepted or dropped.
    always_comb begin
        state_d     = state_q;
        lock_ch_d   = lock_ch_q;
        grant_vld_s = 1'b0;
        grant_s     = {CH_W{1'b0}};
        case (state_q)
            ARB: begin
                grant_vld_s = sel_vld_s;
                grant_s     = sel_s;
                if (sel_vld_s && !mem_ready) begin
                    state_d   = HOLD;
                    lock_ch_d = sel_s;
                end else begin
                    state_d   = ARB;
                end
            end
            HOLD: begin
                grant_s     = lock_ch_q;
                grant_vld_s = ch_valid[lock_ch_q];
                if (!ch_valid[lock_ch_q] || mem_ready) begin
                    state_d = ARB;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // Sticky error when a response shows up with nothing outstanding.
    always_comb begin
        if (mem_rvalid && fifo_empty_s) begin
            resp_err_d = 1'b1;
        end else begin
            resp_err_d = resp_err_q;
        end
    end

    // Drive the memory port from the granted channel and route responses back.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        mem_wstrb = {STRB_W{1'b0}};
        ch_ready  = {NCH{1'b0}};
        ch_rvalid = {NCH{1'b0}};
        ch_rdata  = {DATA_W{1'b0}};
        if (resetb && grant_vld_s) begin
            mem_valid         = 1'b1;
            mem_we            = ch_we[grant_s];
            mem_addr          = ch_addr[int'(grant_s)*ADDR_W +: ADDR_W];
            mem_wdata         = ch_wdata[int'(grant_s)*DATA_W +: DATA_W];
            mem_wstrb         = ch_wstrb[int'(grant_s)*STRB_W +: STRB_W];
            ch_ready[grant_s] = mem_ready;
        end else begin
            mem_valid = 1'b0;
        end
        if (fifo_pop_s) begin
            ch_rvalid[fifo_dout_s] = 1'b1;
        end else begin
            ch_rvalid = {NCH{1'b0}};
        end
        if (resetb) begin
            ch_rdata = mem_rdata;
        end else begin
            ch_rdata = {DATA_W{1'b0}};
        end
    end

    // FSM, lock channel and error flag registers.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= ARB;
            lock_ch_q  <= {CH_W{1'b0}};
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_ch_q  <= lock_ch_d;
            resp_err_q <= resp_err_d;
        end
    end

    resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .W     (CH_W)
    ) u_resp_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (fifo_push_s),
        .pop    (fifo_pop_s),
        .din    (grant_s),
        .dout   (fifo_dout_s),
        .full   (fifo_full_s),
        .empty  (fifo_empty_s)
    );

endmodule
